// File: rtl/dm_cache_ctrl_pkg.sv
// Shared encodings for the direct-mapped write-through cache controller:
// FSM states, stats-window offsets, CTRL bit positions and a byte-merge helper.
package dm_cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEM_REQ = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    localparam logic [31:0] OFF_HITS   = 32'd0;
    localparam logic [31:0] OFF_MISSES = 32'd4;
    localparam logic [31:0] OFF_CTRL   = 32'd8;

    localparam int FLUSH_BIT   = 0;
    localparam int CLRSTAT_BIT = 1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU-side and backing-side native memory buses of the cache controller.
// The slave modport is the controller's view; master is the surrounding system.
interface dm_cache_ctrl_if;

    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_ready, mem_rdata,
        output cpu_ready, cpu_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_ready, mem_rdata,
        input  cpu_ready, cpu_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/dm_cache_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache with one-word lines,
// hit/miss statistics and a flush control exposed through three MMIO words.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int          NUM_LINES = 64,
    parameter int          MEM_WORDS = 16384,
    parameter int          STAT_W    = 32,
    parameter logic [31:0] STAT_BASE = 32'h1000_0020
) (
    input logic            clk,
    input logic            resetn,
    dm_cache_ctrl_if.slave bus
);

    localparam int          IDX_W     = $clog2(NUM_LINES);
    localparam int          TAG_W     = 30 - IDX_W;
    localparam logic [32:0] CACHE_END = 33'(MEM_WORDS) * 33'd4;

    state_t              r_state;
    logic                r_cpu_ready;
    logic [31:0]         r_cpu_rdata;
    logic                r_mem_valid;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_wstrb;
    logic                r_fill;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag_arr  [NUM_LINES];
    logic [31:0]         r_data_arr [NUM_LINES];

    logic [IDX_W-1:0]    w_idx, w_fill_idx;
    logic [TAG_W-1:0]    w_tag, w_fill_tag;
    logic                w_accept, w_cacheable, w_rd, w_hit;
    logic                w_is_hits, w_is_misses, w_is_ctrl, w_is_stat;
    logic                w_hit_inc, w_miss_inc, w_wr_hit, w_ctrl_wr;
    logic                w_flush, w_clr_stat, w_fill;
    logic [STAT_W-1:0]   w_hits, w_misses;
    logic [31:0]         w_stat_rdata;

    assign w_idx       = bus.cpu_addr[IDX_W+1:2];
    assign w_tag       = bus.cpu_addr[31:IDX_W+2];
    assign w_fill_idx  = r_mem_addr[IDX_W+1:2];
    assign w_fill_tag  = r_mem_addr[31:IDX_W+2];

    assign w_accept    = (r_state == S_IDLE) && bus.cpu_valid;
    assign w_rd        = (bus.cpu_wstrb == 4'b0000);
    assign w_cacheable = ({1'b0, bus.cpu_addr} < CACHE_END);
    assign w_is_hits   = (bus.cpu_addr == STAT_BASE + OFF_HITS);
    assign w_is_misses = (bus.cpu_addr == STAT_BASE + OFF_MISSES);
    assign w_is_ctrl   = (bus.cpu_addr == STAT_BASE + OFF_CTRL);
    assign w_is_stat   = w_is_hits || w_is_misses || w_is_ctrl;
    assign w_hit       = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);

    assign w_hit_inc   = w_accept && !w_is_stat && w_cacheable && w_rd && w_hit;
    assign w_miss_inc  = w_accept && !w_is_stat && w_cacheable && w_rd && !w_hit;
    assign w_wr_hit    = w_accept && !w_is_stat && w_cacheable && !w_rd && w_hit;
    assign w_ctrl_wr   = w_accept && w_is_ctrl && !w_rd;
    assign w_flush     = w_ctrl_wr && bus.cpu_wdata[FLUSH_BIT];
    assign w_clr_stat  = w_ctrl_wr && bus.cpu_wdata[CLRSTAT_BIT];
    assign w_fill      = (r_state == S_MEM_REQ) && bus.mem_ready && r_fill;

    sat_counter #(.W(STAT_W)) u_hit_cnt (
        .clk     (clk),
        .rst_n   (resetn),
        .i_inc   (w_hit_inc),
        .i_clr   (w_clr_stat),
        .o_count (w_hits)
    );

    sat_counter #(.W(STAT_W)) u_miss_cnt (
        .clk     (clk),
        .rst_n   (resetn),
        .i_inc   (w_miss_inc),
        .i_clr   (w_clr_stat),
        .o_count (w_misses)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_stat_rdata = 32'h0;
        if (w_is_hits)   w_stat_rdata = 32'(w_hits);
        if (w_is_misses) w_stat_rdata = 32'(w_misses);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= 32'h0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
            r_fill      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cpu_ready <= 1'b0;
                    if (bus.cpu_valid) begin
                        if (w_is_stat) begin
                            r_cpu_rdata <= w_stat_rdata;
                            r_cpu_ready <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (w_hit_inc) begin
                            r_cpu_rdata <= r_data_arr[w_idx];
                            r_cpu_ready <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            // Misses, all writes and uncached traffic go to the backing side.
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= bus.cpu_addr;
                            r_mem_wdata <= bus.cpu_wdata;
                            r_mem_wstrb <= bus.cpu_wstrb;
                            r_fill      <= w_cacheable && w_rd;
                            r_state     <= S_MEM_REQ;
                        end
                    end
                end
                S_MEM_REQ: begin
                    if (bus.mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_cpu_rdata <= bus.mem_rdata;
                        r_cpu_ready <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_cpu_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_cpu_ready <= 1'b0;
                    r_mem_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
        end else if (w_flush) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are deliberately unreset; r_valid gates every use of them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data_arr[w_fill_idx] <= bus.mem_rdata;
            r_tag_arr[w_fill_idx]  <= w_fill_tag;
        end else if (w_wr_hit) begin
            r_data_arr[w_idx] <= merge_bytes(r_data_arr[w_idx], bus.cpu_wdata, bus.cpu_wstrb);
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl; a second instance with 2-bit counters runs
// in lockstep on the same inputs to exercise counter saturation.
module tb_dm_cache_ctrl;

    localparam logic [31:0] HITS_A = 32'h1000_0020;
    localparam logic [31:0] MISS_A = 32'h1000_0024;
    localparam logic [31:0] CTRL_A = 32'h1000_0028;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    dm_cache_ctrl_if bus ();
    dm_cache_ctrl_if bus2 ();

    dm_cache_ctrl u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    dm_cache_ctrl #(.STAT_W(2)) u_dut_sat (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2)
    );

    assign bus2.cpu_valid = bus.cpu_valid;
    assign bus2.cpu_addr  = bus.cpu_addr;
    assign bus2.cpu_wdata = bus.cpu_wdata;
    assign bus2.cpu_wstrb = bus.cpu_wstrb;
    assign bus2.mem_ready = bus.mem_ready;
    assign bus2.mem_rdata = bus.mem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory model with programmable response delay and an access log.
    logic [31:0] bmem [logic [31:0]];
    int          mem_delay   = 1;
    int          wait_cnt    = 0;
    int          mem_count   = 0;
    bit          stray_pulse = 0;
    logic [31:0] log_addr, log_wdata;
    logic [3:0]  log_wstrb;

    always @(negedge clk) begin
        if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
        end else if (stray_pulse) begin
            stray_pulse   = 0;
            bus.mem_rdata = 32'hBAD0_BAD0;
            bus.mem_ready = 1'b1;
        end else if (bus.mem_valid) begin
            wait_cnt++;
            if (wait_cnt >= mem_delay) begin
                logic [31:0] cur;
                wait_cnt  = 0;
                mem_count++;
                log_addr  = bus.mem_addr;
                log_wdata = bus.mem_wdata;
                log_wstrb = bus.mem_wstrb;
                cur = bmem.exists(bus.mem_addr) ? bmem[bus.mem_addr] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                if (bus.mem_wstrb != 4'h0) bmem[bus.mem_addr] = cur;
                bus.mem_rdata = cur;
                bus.mem_ready = 1'b1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic cpu_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                              output logic [31:0] rd, output logic [31:0] rd2,
                              output int lat, output int nmem);
        int m0;
        m0  = mem_count;
        rd  = 32'h0;
        rd2 = 32'h0;
        lat = 0;
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_wstrb = ws;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.cpu_ready) begin
                rd  = bus.cpu_rdata;
                rd2 = bus2.cpu_rdata;
                break;
            end
            if (lat > 200) begin
                checks++; errors++;
                $display("FAIL timeout: no cpu_ready for addr %h after %0d cycles", a, lat);
                break;
            end
        end
        bus.cpu_valid = 1'b0;
        bus.cpu_wstrb = 4'h0;
        nmem = mem_count - m0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, rd2;
        int lat, nm;
        resetn        = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.cpu_wstrb = 4'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        #12;
        checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready: got %b want 0", bus.cpu_ready); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h want 0", bus.cpu_rdata); end
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %b want 0", bus.mem_valid); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (bus.mem_wstrb !== 4'h0) begin errors++; $display("FAIL rst_mem_wstrb: got %h want 0", bus.mem_wstrb); end
        @(negedge clk);
        resetn = 1'b1;
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_hits: got %h want 0", rd); end
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_misses: got %h want 0", rd); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL stat_latency: got %0d want 1", lat); end
    endtask

    task automatic test_miss_then_hit();
        logic [31:0] rd, rd2;
        int lat, nm;
        bmem[32'h100] = 32'hDEAD_BEEF;
        mem_delay = 3;
        cpu_access(32'h100, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_rdata: got %h want deadbeef", rd); end
        checks++; if (nm !== 1 || log_addr !== 32'h100 || log_wstrb !== 4'h0) begin errors++; $display("FAIL miss_backing: got n=%0d addr=%h strb=%h want n=1 addr=100 strb=0", nm, log_addr, log_wstrb); end
        mem_delay = 1;
        cpu_access(32'h100, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_rdata: got %h want deadbeef", rd); end
        checks++; if (lat !== 1 || nm !== 0) begin errors++; $display("FAIL hit_timing: got lat=%0d mem=%0d want lat=1 mem=0", lat, nm); end
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL mth_hits: got %0d want 1", rd); end
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL mth_misses: got %0d want 1", rd); end
    endtask

    task automatic test_conflict();
        logic [31:0] rd, rd2;
        int lat, nm;
        bmem[32'h200] = 32'h1234_5678;
        cpu_access(32'h200, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'h1234_5678 || nm !== 1) begin errors++; $display("FAIL conflict_fill: got %h mem=%0d want 12345678 mem=1", rd, nm); end
        cpu_access(32'h100, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hDEAD_BEEF || nm !== 1) begin errors++; $display("FAIL conflict_evict: got %h mem=%0d want deadbeef mem=1", rd, nm); end
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL conflict_misses: got %0d want 3", rd); end
    endtask

    task automatic test_write_through();
        logic [31:0] rd, rd2;
        int lat, nm;
        cpu_access(32'h100, 32'h0000_5500, 4'b0010, rd, rd2, lat, nm);
        checks++; if (nm !== 1 || log_addr !== 32'h100 || log_wdata !== 32'h0000_5500 || log_wstrb !== 4'b0010) begin errors++; $display("FAIL wt_forward: got n=%0d addr=%h data=%h strb=%b want 1/100/00005500/0010", nm, log_addr, log_wdata, log_wstrb); end
        cpu_access(32'h100, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hDEAD_55EF || nm !== 0) begin errors++; $display("FAIL wt_merge: got %h mem=%0d want dead55ef mem=0", rd, nm); end
        cpu_access(32'h300, 32'hAAAA_AAAA, 4'hF, rd, rd2, lat, nm);
        cpu_access(32'h100, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hDEAD_55EF || nm !== 0) begin errors++; $display("FAIL wt_no_alloc: got %h mem=%0d want dead55ef mem=0", rd, nm); end
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL wt_hits: got %0d want 3 (writes not counted)", rd); end
        cpu_access(32'h300, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hAAAA_AAAA || nm !== 1) begin errors++; $display("FAIL wt_miss_read: got %h mem=%0d want aaaaaaaa mem=1", rd, nm); end
    endtask

    task automatic test_uncached();
        logic [31:0] rd, rd2;
        int lat, nm;
        cpu_access(32'h1000_0000, 32'h0000_0007, 4'hF, rd, rd2, lat, nm);
        checks++; if (nm !== 1 || log_addr !== 32'h1000_0000 || log_wdata !== 32'h7 || log_wstrb !== 4'hF) begin errors++; $display("FAIL unc_forward: got n=%0d addr=%h data=%h strb=%h want 1/10000000/7/f", nm, log_addr, log_wdata, log_wstrb); end
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL unc_hits: got %0d want 3", rd); end
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL unc_misses: got %0d want 4", rd); end
        cpu_access(32'h300, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hAAAA_AAAA || nm !== 0) begin errors++; $display("FAIL unc_cache_kept: got %h mem=%0d want aaaaaaaa mem=0", rd, nm); end
        bmem[32'hFFFC]  = 32'hCAFE_F00D;
        bmem[32'h10000] = 32'h0BAD_CAFE;
        cpu_access(32'hFFFC, 32'h0, 4'h0, rd, rd2, lat, nm);
        cpu_access(32'hFFFC, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hCAFE_F00D || nm !== 0) begin errors++; $display("FAIL top_word_cached: got %h mem=%0d want cafef00d mem=0", rd, nm); end
        cpu_access(32'h10000, 32'h0, 4'h0, rd, rd2, lat, nm);
        cpu_access(32'h10000, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'h0BAD_CAFE || nm !== 1) begin errors++; $display("FAIL past_end_uncached: got %h mem=%0d want 0badcafe mem=1", rd, nm); end
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL bound_hits: got %0d want 5", rd); end
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL bound_misses: got %0d want 5", rd); end
    endtask

    task automatic test_stray_ready();
        logic [31:0] rd, rd2;
        int lat, nm;
        bit seen;
        seen = 0;
        stray_pulse = 1;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ready) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stray_ready: got cpu_ready=1 want 0"); end
        cpu_access(32'h300, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hAAAA_AAAA || nm !== 0) begin errors++; $display("FAIL stray_cache: got %h mem=%0d want aaaaaaaa mem=0", rd, nm); end
    endtask

    task automatic test_flush_clear();
        logic [31:0] rd, rd2;
        int lat, nm;
        cpu_access(CTRL_A, 32'h3, 4'hF, rd, rd2, lat, nm);
        checks++; if (nm !== 0) begin errors++; $display("FAIL ctrl_no_backing: got mem=%0d want 0", nm); end
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL clr_hits: got %0d want 0", rd); end
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL clr_misses: got %0d want 0", rd); end
        cpu_access(CTRL_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL ctrl_read: got %h want 0", rd); end
        cpu_access(32'h300, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (nm !== 1) begin errors++; $display("FAIL flush_miss: got mem=%0d want 1", nm); end
        cpu_access(32'h300, 32'h0, 4'h0, rd, rd2, lat, nm);
        cpu_access(CTRL_A, 32'h1, 4'hF, rd, rd2, lat, nm);
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL flush_only_hits: got %0d want 1", rd); end
        cpu_access(32'h300, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (nm !== 1) begin errors++; $display("FAIL flush_only_miss: got mem=%0d want 1", nm); end
        cpu_access(CTRL_A, 32'h2, 4'hF, rd, rd2, lat, nm);
        cpu_access(32'h300, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (nm !== 0) begin errors++; $display("FAIL clr_only_keeps_lines: got mem=%0d want 0", nm); end
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL clr_only_hits: got %0d want 1", rd); end
    endtask

    task automatic test_saturation();
        logic [31:0] rd, rd2;
        int lat, nm;
        for (int i = 0; i < 4; i++)
            cpu_access((i % 2 == 0) ? 32'h100 : 32'h200, 32'h0, 4'h0, rd, rd2, lat, nm);
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd4 || rd2 !== 32'd3) begin errors++; $display("FAIL sat_reach: got %0d/%0d want 4/3", rd, rd2); end
        cpu_access(32'h100, 32'h0, 4'h0, rd, rd2, lat, nm);
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd5 || rd2 !== 32'd3) begin errors++; $display("FAIL sat_hold: got %0d/%0d want 5/3", rd, rd2); end
        cpu_access(MISS_A, 32'h0, 4'hF, rd, rd2, lat, nm);
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL misses_ro: got %0d want 5", rd); end
        cpu_access(HITS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd1 || rd2 !== 32'd1) begin errors++; $display("FAIL sat_hits: got %0d/%0d want 1/1", rd, rd2); end
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] rd, rd2;
        int lat, nm;
        bmem[32'h140] = 32'h0014_0140;
        mem_delay = 100000;
        @(negedge clk);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h140;
        bus.cpu_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h140) begin errors++; $display("FAIL mid_miss_pending: got valid=%b addr=%h want 1/140", bus.mem_valid, bus.mem_addr); end
        #3 resetn = 1'b0;
        #1;
        checks++; if (bus.mem_valid !== 1'b0 || bus.mem_addr !== 32'h0 || bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL async_reset: got valid=%b addr=%h ready=%b want 0/0/0", bus.mem_valid, bus.mem_addr, bus.cpu_ready); end
        bus.cpu_valid = 1'b0;
        @(negedge clk);
        mem_delay = 1;
        resetn = 1'b1;
        cpu_access(32'h100, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'hDEAD_55EF || nm !== 1) begin errors++; $display("FAIL post_rst_invalid: got %h mem=%0d want dead55ef mem=1", rd, nm); end
        cpu_access(32'h140, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'h0014_0140 || nm !== 1) begin errors++; $display("FAIL post_rst_remiss: got %h mem=%0d want 00140140 mem=1", rd, nm); end
        cpu_access(MISS_A, 32'h0, 4'h0, rd, rd2, lat, nm);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL post_rst_misses: got %0d want 2", rd); end
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_conflict();
        test_write_through();
        test_uncached();
        test_stray_ready();
        test_flush_clear();
        test_saturation();
        test_reset_mid_miss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
